// File: rtl/wb_picorv32_bridge.sv
// PicoRV32 native memory bus to Wishbone pipelined master with a bounded bus cycle.
// Errors and timeouts return ERR_RDATA and raise a sticky flag.
module wb_picorv32_bridge #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_valid,
    input  logic        i_mem_instr,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_wstrb,
    output logic        o_mem_ready,
    output logic [31:0] o_mem_rdata,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    output logic        o_bus_err,
    input  logic        i_clr_err
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, data_q, data_d;
    logic [3:0]  sel_q, sel_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_set, resp;

    // The fetch/data distinction does not affect the bus transaction.
    logic        unused_instr;
    assign unused_instr = i_mem_instr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        resp    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_mem_valid) begin
                    state_d = S_REQ;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    addr_d  = i_mem_addr;
                    data_d  = i_mem_wdata;
                    we_d    = |i_mem_wstrb;
                    sel_d   = (|i_mem_wstrb) ? i_mem_wstrb : 4'hF;
                    cnt_d   = '0;
                end
            end
            S_REQ, S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // Responses during a stalled strobe belong to no accepted request.
                resp  = (state_q == S_WAIT || !i_wb_stall) && (i_wb_ack || i_wb_err);
                if (resp) begin
                    state_d = S_DONE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    ready_d = 1'b1;
                    rdata_d = i_wb_err ? ERR_RDATA : i_wb_data;
                    err_set = i_wb_err;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_DONE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    ready_d = 1'b1;
                    rdata_d = ERR_RDATA;
                    err_set = 1'b1;
                end else if (state_q == S_REQ && !i_wb_stall) begin
                    state_d = S_WAIT;
                    stb_d   = 1'b0;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        err_d = err_set || (err_q && !i_clr_err);
    end

    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_we     = we_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_data   = data_q;
    assign o_wb_sel    = sel_q;
    assign o_mem_ready = ready_q;
    assign o_mem_rdata = rdata_q;
    assign o_bus_err   = err_q;
endmodule

// File: tb/tb_wb_picorv32_bridge.sv
// Randomized bench for wb_picorv32_bridge: each transfer's outcome is predicted from
// stall/wait/response counts against the timeout bound.
module tb_wb_picorv32_bridge;
    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_valid = 0, mem_instr = 0;
    logic [31:0] mem_addr = 0, mem_wdata = 0;
    logic [3:0]  mem_wstrb = 0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_addr, wb_dout;
    logic [3:0]  wb_sel;
    logic        wb_stall = 0, wb_ack = 0, wb_err = 0;
    logic [31:0] wb_din = 0;
    logic        bus_err;
    logic        clr_err = 0;

    int  n_tests = 0, n_fail = 0;
    bit  err_m = 0;

    wb_picorv32_bridge #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_mem_valid(mem_valid), .i_mem_instr(mem_instr), .i_mem_addr(mem_addr),
        .i_mem_wdata(mem_wdata), .i_mem_wstrb(mem_wstrb),
        .o_mem_ready(mem_ready), .o_mem_rdata(mem_rdata),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_addr(wb_addr), .o_wb_data(wb_dout), .o_wb_sel(wb_sel),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_din),
        .o_bus_err(bus_err), .i_clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advances one clock; the sticky flag model follows set-over-clear.
    task automatic tick(input bit set);
        err_m = set || (err_m && !clr_err);
        @(posedge clk);
        #1;
    endtask

    // resp: 0 none, 1 ack, 2 err, 3 ack+err. clr_mode: 0 none, 1 random, 2 on response cycle.
    task automatic xfer(input logic [3:0] wstrb, input logic [31:0] addr, input logic [31:0] wdata,
                        input int s, input int w, input int resp, input logic [31:0] rd,
                        input int clr_mode);
        int  r, rend, cyc_n, stb_n;
        bit  tmo, set_err, got, noise;
        logic [31:0] exp_rdata;
        r         = s + 1 + w;
        tmo       = (resp == 0) || (r > T);
        rend      = tmo ? T : r;
        set_err   = tmo || (resp >= 2);
        exp_rdata = set_err ? ERR : rd;
        cyc_n = 0; stb_n = 0; got = 0;

        mem_valid = 1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
        mem_instr = 1'($urandom_range(0, 1));
        tick(0);
        for (int c = 1; c <= T + 4; c++) begin
            check("bus_err", {31'd0, bus_err}, {31'd0, err_m});
            if (mem_ready) begin
                got = 1;
                check("ready_cycle", c, rend + 1);
                check("rdata", mem_rdata, exp_rdata);
                check("cyc_at_ready", {31'd0, wb_cyc}, 32'd0);
                break;
            end
            if (c == 1) begin
                check("addr", wb_addr, addr);
                check("wdata", wb_dout, wdata);
                check("we", {31'd0, wb_we}, {31'd0, (wstrb != 0)});
                check("sel", {28'd0, wb_sel}, {28'd0, (wstrb != 0) ? wstrb : 4'hF});
            end
            cyc_n += int'(wb_cyc);
            stb_n += int'(wb_stb);
            wb_stall = (c <= s);
            noise    = (c <= s) && ($urandom_range(0, 3) == 0);
            wb_ack   = ((c == r) && (resp == 1 || resp == 3)) || noise;
            wb_err   = ((c == r) && resp >= 2) || (noise && $urandom_range(0, 1) == 1);
            wb_din   = (c == r) ? rd : $urandom;
            clr_err  = (clr_mode == 1) ? ($urandom_range(0, 4) == 0)
                                       : ((clr_mode == 2) && (c == rend));
            tick((c == rend) && set_err);
        end
        if (!got) check("ready_seen", 0, 1);
        check("cyc_cycles", cyc_n, rend);
        check("stb_cycles", stb_n, (s + 1 < rend) ? s + 1 : rend);
        mem_valid = 0; wb_stall = 0; wb_ack = 0; wb_err = 0; clr_err = 0;
        tick(0);
        check("ready_single", {31'd0, mem_ready}, 32'd0);
        check("bus_err_after", {31'd0, bus_err}, {31'd0, err_m});
    endtask

    task automatic clr_pulse;
        clr_err = 1;
        tick(0);
        clr_err = 0;
        check("clr_err", {31'd0, bus_err}, {31'd0, err_m});
    endtask

    initial begin
        @(posedge clk);
        #1;
        check("rst_cyc", {31'd0, wb_cyc}, 32'd0);
        check("rst_stb", {31'd0, wb_stb}, 32'd0);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        #3 rst = 0;
        @(posedge clk);
        #1;

        xfer(4'hF, 32'h0000_1000, 32'h0000_002A, 0, 0, 1, 32'h0, 0);          // LED write
        xfer(4'h0, 32'h0000_2000, 32'h0, 3, 1, 1, 32'h1234_5678, 0);           // stalled read
        xfer(4'b0100, 32'h0000_1004, 32'hA5A5_A5A5, 0, 1, 1, 32'h0, 0);        // byte write
        xfer(4'h0, 32'h0000_1004, 32'h0, 0, 0, 1, 32'hCAFE_F00D, 0);
        xfer(4'h0, 32'h0000_3000, 32'h0, 0, 1, 3, 32'h5555_AAAA, 0);           // ack+err
        clr_pulse();
        xfer(4'h0, 32'h0000_3000, 32'h0, 1, 0, 2, 32'h0, 2);                   // clear meets err
        clr_pulse();
        xfer(4'h0, 32'h0000_4000, 32'h0, 0, 0, 0, 32'h0, 0);                   // timeout
        xfer(4'h0, 32'h0000_4000, 32'h0, 0, 0, 1, 32'h0BAD_BEEF, 0);
        xfer(4'h0, 32'h0000_4004, 32'h0, 3, 4, 1, 32'h7777_0001, 0);           // ack in last cycle
        xfer(4'h0, 32'h0000_4008, 32'h0, 9, 0, 1, 32'h7777_0002, 0);           // timeout while stalled

        for (int i = 0; i < 60; i++) begin
            int resp;
            resp = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
            if ($urandom_range(0, 2) != 0) resp = 1;
            xfer(4'($urandom), $urandom, $urandom, int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)), resp, $urandom, 1);
            if ($urandom_range(0, 1) == 1) tick(0);
        end

        // Reset asserted between edges while waiting for an ack.
        mem_valid = 1; mem_addr = 32'h0000_5000; mem_wstrb = 4'h0;
        tick(0);
        tick(0);
        tick(0);
        #2 rst = 1;
        #1;
        err_m = 0;
        check("arst_cyc", {31'd0, wb_cyc}, 32'd0);
        check("arst_stb", {31'd0, wb_stb}, 32'd0);
        check("arst_ready", {31'd0, mem_ready}, 32'd0);
        check("arst_bus_err", {31'd0, bus_err}, 32'd0);
        mem_valid = 0;
        #2 rst = 0;
        @(posedge clk);
        #1;
        xfer(4'hF, 32'h0000_1000, 32'h0000_0011, 0, 0, 1, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_picorv32_bridge.md
# wb_picorv32_bridge

Bus master stage directly upstream of the Wishbone peripherals (LED register, etc.) on the Tang Nano 9K SoC. It converts the PicoRV32 native memory interface (valid/ready) into single Wishbone pipelined-mode transactions and returns read data and completion to the core. It also bounds every bus cycle with a timeout and reports errors and timeouts through a sticky flag.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles `o_wb_cyc` may stay high before the bridge aborts the transfer; range 2..65535.
- `ERR_RDATA`, default 32'hFFFF_FFFF: read data returned to the core on a bus error or timeout.

Ports (name, direction, width, meaning):
- `i_clk` in 1: system clock.
- `i_reset` in 1: **asynchronous, active-high reset**.
- `i_mem_valid` in 1: core request.
- `i_mem_instr` in 1: instruction fetch; informational only, ignored.
- `i_mem_addr` in 32: byte address.
- `i_mem_wdata` in 32: write data.
- `i_mem_wstrb` in 4: byte strobes; 0 means read.
- `o_mem_ready` out 1: one-cycle completion pulse to the core.
- `o_mem_rdata` out 32: read data, valid while `o_mem_ready` is high.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each: Wishbone master controls.
- `o_wb_addr` out 32, `o_wb_data` out 32, `o_wb_sel` out 4: address, write data and byte selects.
- `i_wb_stall`, `i_wb_ack`, `i_wb_err` in 1 each: slave responses.
- `i_wb_data` in 32: slave read data.
- `o_bus_err` out 1: sticky error/timeout flag.
- `i_clr_err` in 1: clears `o_bus_err`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. All outputs are registered.
- Reset, applied at any time including mid-transfer:
  - state returns to IDLE;
  - every output is 0, including `o_wb_cyc`, `o_wb_stb`, `o_mem_ready`, `o_mem_rdata` and `o_bus_err`;
  - the timeout counter is 0.
- IDLE: on `i_mem_valid`=1, the bridge latches the request and moves to REQ with `o_wb_cyc`=`o_wb_stb`=1.
  - `o_wb_addr` = `i_mem_addr`; `o_wb_data` = `i_mem_wdata`.
  - `o_wb_we` = |`i_mem_wstrb`.
  - `o_wb_sel` = `i_mem_wstrb` for writes, 4'b1111 for reads.
- REQ: `o_wb_stb` stays high while `i_wb_stall`=1. When stall is 0, the request is accepted and `o_wb_stb` drops on the next edge.
  - If ack or err arrives in the same cycle as acceptance (combinational-ack slaves such as the LED register), the bridge goes directly to DONE.
  - Otherwise it goes to WAIT.
  - Ack or err while stalled is a slave protocol violation and is ignored.
- WAIT: `o_wb_cyc`=1, `o_wb_stb`=0. The bridge waits for `i_wb_ack` or `i_wb_err`, then goes to DONE.
- Entry to DONE:
  - `o_wb_cyc` drops.
  - `o_mem_rdata` is loaded with `i_wb_data` on ack, or with `ERR_RDATA` on err or timeout. For writes it is loaded the same way; the core ignores it.
  - `o_mem_ready` pulses high for exactly one cycle.
- DONE: returns to IDLE next cycle.
- Back-to-back requests: `i_mem_valid` seen in the IDLE cycle right after DONE starts a new transfer. Minimum spacing is one IDLE cycle.
- Simultaneous ack and err: err wins; `ERR_RDATA` is returned and `o_bus_err` is set.
- Timeout:
  - A 16-bit counter clears on entry to REQ and increments every REQ/WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES`-1 with no accepted ack or err, the bridge aborts: `o_wb_cyc` and `o_wb_stb` drop, `ERR_RDATA` is returned, `o_bus_err` is set, and the FSM enters DONE.
  - Ack or err arriving in that same final cycle takes priority over the timeout.
- `o_bus_err`: set on err or timeout; cleared by `i_clr_err`. If set and clear occur in the same cycle, set wins.
- Dropping `i_mem_valid` mid-transfer is illegal for the core. The bridge completes the bus cycle regardless.
- Latched bus outputs are held stable from REQ through DONE.

## Timing
- Cycle 0: `i_mem_valid` sampled in IDLE.
- Cycle 1: `o_wb_cyc` and `o_wb_stb` high (REQ).
- Combinational-ack slave, no stall: ack in cycle 1; `o_mem_ready` in cycle 2. Total latency is 2 cycles.
- Registered-ack slave: ack in cycle 2; `o_mem_ready` in cycle 3.
- Each stall cycle adds one cycle; each wait-for-ack cycle adds one cycle.
- Timeout abort: `o_wb_cyc` is high for exactly `TIMEOUT_CYCLES` cycles. `o_mem_ready` follows in the next cycle.

## Test plan
- LED write: core writes 32'h0000_002A to the LED address with wstrb 4'b1111 against a combinational-ack slave.
  - Required: one cycle of stb with we=1, sel=4'hF, data 32'h2A; `o_mem_ready` 2 cycles after valid; `o_bus_err`=0.
- Read with stall: slave stalls 3 cycles, then acks one cycle later with 32'h1234_5678.
  - Required: stb high for 4 cycles; `o_mem_rdata`=32'h1234_5678 with a single ready pulse; cyc drops together with the ready edge.
- Byte write: wstrb 4'b0100.
  - Required: `o_wb_sel`=4'b0100, we=1.
  - Then a read with wstrb 0 yields sel=4'hF, we=0.
- Error: slave asserts ack and err together.
  - Required: `o_mem_rdata`=32'hFFFF_FFFF, `o_bus_err`=1.
  - `i_clr_err` pulse clears the flag; a clear coinciding with a new err leaves it at 1.
- Timeout with `TIMEOUT_CYCLES`=8 and a slave that never acks.
  - Required: cyc high exactly 8 cycles, then a ready pulse with rdata 32'hFFFF_FFFF and `o_bus_err`=1.
  - The next transfer succeeds normally.
- Reset mid-WAIT: assert `i_reset` between clock edges.
  - Required: `o_wb_cyc`, `o_wb_stb` and `o_mem_ready` drop immediately, without waiting for a clock edge.
  - After release, the state is IDLE and a new request completes in 2 cycles.
